// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready FIFO front end feeding a framed LSB-first serialiser.
// Optional line-break generation (break_req port, BREAK/MARK states) is built with UART_TX_BREAK_EN.
module uart_tx_param #(
    parameter int BAUD_DIV  = 108,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk50M,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 rs232_tx,
    output logic                 tx_idle
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                 break_req
`endif
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [15:0]        BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]         DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]         STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
`ifdef UART_TX_BREAK_EN
    localparam logic [3:0]         FRAME_CNT  = 4'(1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK,
        S_MARK
`endif
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, fifo_empty;

    assign tx_ready   = (fifo_level != LEVEL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = tx_valid & tx_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk50M) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- serialiser FSM ----------------
    state_t               state, state_nxt;
    logic [15:0]          baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 line_nxt;
    logic                 bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign tx_idle = fifo_empty && (state == S_IDLE);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            rs232_tx <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_nxt;
            rs232_tx <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 16'd1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                baud_nxt = '0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_nxt = S_BREAK;
                    bit_nxt   = '0;
                end else
`endif
                if (!fifo_empty) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = S_IDLE;
`ifdef UART_TX_BREAK_EN
                        if (break_req) state_nxt = S_BREAK;
                        else
`endif
                        if (!fifo_empty) pop = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // bit_cnt counts elapsed bit periods (saturating) to guarantee a full frame of low line
            S_BREAK: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt != FRAME_CNT) bit_nxt = bit_cnt + 4'd1;
                end
                if (!break_req && bit_cnt == FRAME_CNT) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_MARK;
                end
            end
            S_MARK: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
        // popping a word always starts a new frame, from IDLE or straight out of STOP
        if (pop) begin
            shreg_nxt = head;
            par_nxt   = (PARITY == 1) ? ~^head : ^head;
            baud_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = S_START;
        end
    end

    // the line is registered from the current state, so it lags the FSM by one clock
    always_comb begin
        line_nxt = 1'b1;
        case (state)
            S_START:  line_nxt = 1'b0;
            S_DATA:   line_nxt = shreg[0];
            S_PARITY: line_nxt = par_bit;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  line_nxt = 1'b0;
`endif
            default:  line_nxt = 1'b1;
        endcase
    end

endmodule
